// File: rtl/mem_responder_if.sv
// Request/response channel between the core's memory port and mem_responder.
// A request moves on any rising edge where req_valid and req_ready are both high; rsp_valid is a one-cycle pulse.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed RV32I load/store/fetch memory with a fixed access latency,
// little-endian lane selection, sign/zero extension and misalignment/illegal-funct3 flagging.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic [1:0]       dbg_state
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         DIRECT    = (LATENCY == 1);
  localparam logic [3:0] WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              ready_q;
  logic              valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [7:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       a_wdata;
  logic [7:0]        b0, b1, b2, b3;
  logic              err_n;
  logic [31:0]       ld_data;

  assign accept = bus.req_valid & ready_q;

  // With LATENCY=1 the response is formed on the accept edge itself, so the
  // access is decoded from the live request; otherwise from the captured copy.
  assign a_we    = (state == S_IDLE) ? bus.req_we     : cap_we;
  assign a_f3    = (state == S_IDLE) ? bus.req_funct3 : cap_f3;
  assign a0      = (state == S_IDLE) ? bus.req_addr   : cap_addr;
  assign a_wdata = (state == S_IDLE) ? bus.req_wdata  : cap_wdata;
  assign a1      = a0 + ADDR_W'(1);
  assign a2      = a0 + ADDR_W'(2);
  assign a3      = a0 + ADDR_W'(3);

  assign enter_resp = DIRECT ? ((state == S_IDLE) && accept)
                             : ((state == S_WAIT) && (cnt == 4'd0));

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    err_n = 1'b0;
    case (a_f3)
      3'b000:  err_n = 1'b0;
      3'b001:  err_n = a0[0];
      3'b010:  err_n = |a0[1:0];
      3'b100:  err_n = a_we;
      3'b101:  err_n = a_we | a0[0];
      default: err_n = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (a_f3)
      3'b000:  ld_data = {{24{b0[7]}}, b0};
      3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_data = {b3, b2, b1, b0};
      3'b100:  ld_data = {24'h0, b0};
      3'b101:  ld_data = {16'h0, b1, b0};
      default: ld_data = 32'h0;
    endcase
    if (a_we || err_n) ld_data = 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_f3    <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we    <= bus.req_we;
            cap_f3    <= bus.req_funct3;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            ready_q   <= 1'b0;
            if (DIRECT) begin
              state   <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= ld_data;
              err_q   <= err_n;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_RESP;
            valid_q <= 1'b1;
            rdata_q <= ld_data;
            err_q   <= err_n;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; a store lands only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && a_we && !err_n) begin
      mem[a0] <= a_wdata[7:0];
      if (a_f3[1:0] != 2'b00) mem[a1] <= a_wdata[15:8];
      if (a_f3[1:0] == 2'b10) begin
        mem[a2] <= a_wdata[23:16];
        mem[a3] <= a_wdata[31:24];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2 and one at LATENCY=1,
// each with a response scoreboard fed by the request driver.
module tb_mem_responder;

  logic clk;
  logic rst;
  logic [1:0] dbg2, dbg1;

  mem_responder_if #(.ADDR_W(8)) bus2 ();
  mem_responder_if #(.ADDR_W(8)) bus1 ();

  mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(dbg2)
  );

  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [32:0] exp_q2[$];
  logic [32:0] exp_q1[$];
  string       tag_q2[$];
  string       tag_q1[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboards: every rsp_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    logic [32:0] e;
    string t;
    if (bus2.rsp_valid === 1'b1) begin
      if (exp_q2.size() == 0) check("spurious_rsp_l2", 32'd1, 32'd0);
      else begin
        e = exp_q2.pop_front();
        t = tag_q2.pop_front();
        check({t, "_rdata"}, bus2.rsp_rdata, e[31:0]);
        check({t, "_err"}, {31'h0, bus2.rsp_err}, {31'h0, e[32]});
      end
    end
    if (bus1.rsp_valid === 1'b1) begin
      if (exp_q1.size() == 0) check("spurious_rsp_l1", 32'd1, 32'd0);
      else begin
        e = exp_q1.pop_front();
        t = tag_q1.pop_front();
        check({t, "_rdata"}, bus1.rsp_rdata, e[31:0]);
        check({t, "_err"}, {31'h0, bus1.rsp_err}, {31'h0, e[32]});
      end
    end
  end

  // driver helpers
  task automatic set_req(input bit which, input logic v, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd);
    if (which) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
      bus1.req_addr = addr; bus1.req_wdata = wd;
    end else begin
      bus2.req_valid = v; bus2.req_we = we; bus2.req_funct3 = f3;
      bus2.req_addr = addr; bus2.req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input bit which);
    return which ? bus1.req_ready : bus2.req_ready;
  endfunction

  function automatic logic get_rsp_valid(input bit which);
    return which ? bus1.rsp_valid : bus2.rsp_valid;
  endfunction

  task automatic push_exp(input bit which, input string tag, input logic err, input logic [31:0] rd);
    if (which) begin exp_q1.push_back({err, rd}); tag_q1.push_back(tag); end
    else       begin exp_q2.push_back({err, rd}); tag_q2.push_back(tag); end
  endtask

  // one request; checks ready drop and response latency, data via scoreboard
  task automatic do_req(input bit which, input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    lat = which ? 1 : 2;
    @(negedge clk);
    set_req(which, 1'b1, we, f3, addr, wd);
    n = 0;
    while (get_ready(which) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    push_exp(which, tag, exp_err, exp_rd);
    @(posedge clk);
    #1;
    set_req(which, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_ready_busy"}, {31'h0, get_ready(which)}, 32'd0);
    end while (get_rsp_valid(which) !== 1'b1 && n < 20);
    check({tag, "_latency"}, n, lat);
  endtask

  // req_valid held high for three back-to-back SW requests at base, base+4, base+8
  task automatic stream3(input bit which, input string tag, input logic [7:0] base, input logic [31:0] d0);
    int acc, cyc, pulses, last, low_cnt, lat;
    bit take;
    acc = 0; cyc = 0; pulses = 0; last = -1; low_cnt = 0;
    lat = which ? 1 : 2;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_exp(which, {tag, "_sw"}, 1'b0, 32'h0);
    set_req(which, 1'b1, 1'b1, 3'b010, base, d0);
    while (cyc < 60) begin
      if (get_rsp_valid(which) === 1'b1) begin
        pulses++;
        if (last >= 0) check({tag, "_gap"}, cyc - last, lat + 1);
        last = cyc;
      end
      if (get_ready(which) !== 1'b1) low_cnt++;
      if (pulses == 3) break;
      take = (acc < 3) && (get_ready(which) === 1'b1);
      @(posedge clk);
      #1;
      if (take) begin
        acc++;
        if (acc == 3) set_req(which, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
        else set_req(which, 1'b1, 1'b1, 3'b010, base + 8'(4 * acc), d0 + 32'(acc));
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accepts"}, acc, 3);
    check({tag, "_pulses"}, pulses, 3);
    check({tag, "_busy_cycles"}, low_cnt, 3 * lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready2"}, {31'h0, bus2.req_ready}, 32'd1);
    check({tag, "_valid2"}, {31'h0, bus2.rsp_valid}, 32'd0);
    check({tag, "_rdata2"}, bus2.rsp_rdata, 32'h0);
    check({tag, "_err2"}, {31'h0, bus2.rsp_err}, 32'd0);
    check({tag, "_state2"}, {30'h0, dbg2}, 32'd0);
    check({tag, "_ready1"}, {31'h0, bus1.req_ready}, 32'd1);
    check({tag, "_valid1"}, {31'h0, bus1.rsp_valid}, 32'd0);
    check({tag, "_state1"}, {30'h0, dbg1}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // word round trip and sub-word loads
    do_req(1'b0, "sw_10",  1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b0, "lw_10",  1'b0, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, "lb_13",  1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, "lbu_13", 1'b0, 3'b100, 8'h13, 32'h0, 32'h000000DE, 1'b0);
    do_req(1'b0, "lh_10",  1'b0, 3'b001, 8'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req(1'b0, "lhu_12", 1'b0, 3'b101, 8'h12, 32'h0, 32'h0000DEAD, 1'b0);

    // byte/half store merge
    do_req(1'b0, "sb_11",  1'b1, 3'b000, 8'h11, 32'h12345655, 32'h0, 1'b0);
    do_req(1'b0, "sh_12",  1'b1, 3'b001, 8'h12, 32'h0000AAAA, 32'h0, 1'b0);
    do_req(1'b0, "lw_merge", 1'b0, 3'b010, 8'h10, 32'h0, 32'hAAAA55EF, 1'b0);
    do_req(1'b0, "sw_20_clear", 1'b1, 3'b010, 8'h20, 32'h00000000, 32'h0, 1'b0);

    // error cases leave memory untouched
    do_req(1'b0, "err_lw_11", 1'b0, 3'b010, 8'h11, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, "err_sh_13", 1'b1, 3'b001, 8'h13, 32'h77777777, 32'h0, 1'b1);
    do_req(1'b0, "err_f3_011", 1'b0, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, "err_sbu_10", 1'b1, 3'b100, 8'h10, 32'h99999999, 32'h0, 1'b1);
    do_req(1'b0, "lw_after_err", 1'b0, 3'b010, 8'h10, 32'h0, 32'hAAAA55EF, 1'b0);

    // reset during the WAIT cycle of a store
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 3'b010, 8'h20, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    check("mid_wait_state", {30'h0, dbg2}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    do_req(1'b0, "lw_20_after_reset", 1'b0, 3'b010, 8'h20, 32'h0, 32'h00000000, 1'b0);

    // back-to-back streaming, then read back to catch lost or duplicated requests
    stream3(1'b0, "stream_l2", 8'h30, 32'h11110000);
    do_req(1'b0, "rb_l2_30", 1'b0, 3'b010, 8'h30, 32'h0, 32'h11110000, 1'b0);
    do_req(1'b0, "rb_l2_34", 1'b0, 3'b010, 8'h34, 32'h0, 32'h11110001, 1'b0);
    do_req(1'b0, "rb_l2_38", 1'b0, 3'b010, 8'h38, 32'h0, 32'h11110002, 1'b0);

    stream3(1'b1, "stream_l1", 8'h40, 32'h22220000);
    do_req(1'b1, "rb_l1_40", 1'b0, 3'b010, 8'h40, 32'h0, 32'h22220000, 1'b0);
    do_req(1'b1, "rb_l1_44", 1'b0, 3'b010, 8'h44, 32'h0, 32'h22220001, 1'b0);
    do_req(1'b1, "rb_l1_48", 1'b0, 3'b010, 8'h48, 32'h0, 32'h22220002, 1'b0);
    do_req(1'b1, "l1_lh_42", 1'b0, 3'b001, 8'h42, 32'h0, 32'h00002222, 1'b0);
    do_req(1'b1, "l1_err_lh_41", 1'b0, 3'b001, 8'h41, 32'h0, 32'h0, 1'b1);

    repeat (4) @(negedge clk);
    check("exp_q2_drained", exp_q2.size(), 32'd0);
    check("exp_q1_drained", exp_q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
